// File: rtl/digit_sequencer_if.sv
// Host and stepper-drive signals of the digit sequencer.
// master: host/drive side, slave: the sequencer.
interface digit_sequencer_if #(
  parameter int DEPTH = 8
);
  logic                     wr_en;
  logic [3:0]               wr_digit;
  logic                     run;
  logic                     abort;
  logic                     err_clear;
  logic                     at_target;
  logic [3:0]               digit;
  logic                     load;
  logic                     en;
  logic                     busy;
  logic                     done;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     full;
  logic                     empty;
  logic                     overflow;
  logic                     bad_digit;
  logic                     timeout;

  modport master (
    output wr_en, wr_digit, run, abort, err_clear, at_target,
    input  digit, load, en, busy, done, fifo_count,
    input  full, empty, overflow, bad_digit, timeout
  );

  modport slave (
    input  wr_en, wr_digit, run, abort, err_clear, at_target,
    output digit, load, en, busy, done, fifo_count,
    output full, empty, overflow, bad_digit, timeout
  );
endinterface

// File: rtl/digit_sequencer.sv
// Queues digits and strikes them one at a time on a stepper/servo
// drive: issue, settle on target, push, then gap back to rest.
module digit_sequencer #(
  parameter int DEPTH          = 8,
  parameter int SETTLE_HOLD    = 16,
  parameter int PUSH_CYCLES    = 45_000_000,
  parameter int GAP_CYCLES     = 4_000_000,
  parameter int TIMEOUT_CYCLES = 400_000_000
) (
  input logic               clk,
  input logic               reset,
  digit_sequencer_if.slave  bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int HW   = $clog2(SETTLE_HOLD) + 1;
  localparam int PG   = (PUSH_CYCLES > GAP_CYCLES) ?
                        PUSH_CYCLES : GAP_CYCLES;
  localparam int CMAX = (PG > TIMEOUT_CYCLES) ?
                        PG : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [2:0] {
    IDLE, ISSUE, SETTLE, PUSH, GAP, ERROR
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [3:0]      digit_q, digit_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            bad_q, bad_d;
  logic            tmo_q, tmo_d;
  logic [3:0]      mem_q [DEPTH];

  logic full, empty, legal, pop, push;
  logic hold_hit, tmo_hit, push_end, gap_end;
  logic ovf_set, bad_set, tmo_set;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign legal    = (bus.wr_digit <= 4'd9);
  assign pop      = (state_q == ISSUE) && !bus.abort;
  assign push     = bus.wr_en && legal && !bus.abort &&
                    (!full || pop);
  assign ovf_set  = bus.wr_en && legal && full && !pop;
  assign bad_set  = bus.wr_en && !legal;

  assign hold_hit = (state_q == SETTLE) && bus.at_target &&
                    (hold_q + HW'(1) == HW'(SETTLE_HOLD));
  assign tmo_hit  = (state_q == SETTLE) &&
                    (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign push_end = (cnt_q == CW'(PUSH_CYCLES - 1));
  assign gap_end  = (cnt_q == CW'(GAP_CYCLES - 1));
  assign tmo_set  = tmo_hit && !hold_hit && !bus.abort;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (bus.run && !empty) state_d = ISSUE;
      ISSUE:  state_d = SETTLE;
      SETTLE: begin
        if (hold_hit)     state_d = PUSH;
        else if (tmo_hit) state_d = ERROR;
      end
      PUSH:   if (push_end) state_d = GAP;
      GAP: begin
        if (gap_end)
          state_d = (bus.run && !empty) ? ISSUE : IDLE;
      end
      ERROR:  if (bus.err_clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  // Counters restart on every state change.
  always_comb begin
    cnt_d  = (state_d != state_q) ? '0 : cnt_q + CW'(1);
    hold_d = '0;
    if (state_q == SETTLE && state_d == SETTLE)
      hold_d = bus.at_target ? hold_q + HW'(1) : '0;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);
    end
  end

  // Head is latched as ISSUE is entered so it is visible during ISSUE.
  always_comb begin
    digit_d = digit_q;
    if (state_d == ISSUE && state_q != ISSUE)
      digit_d = mem_q[rd_ptr_q];
    done_d = (state_q == PUSH) && push_end && !bus.abort;
    ovf_d  = ovf_set || (ovf_q && !bus.err_clear);
    bad_d  = bad_set || (bad_q && !bus.err_clear);
    tmo_d  = tmo_set || (tmo_q && !bus.err_clear);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      digit_q  <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      bad_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      digit_q  <= digit_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      bad_q    <= bad_d;
      tmo_q    <= tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_digit;
  end

  assign bus.en         = (state_q == ISSUE)  ||
                          (state_q == SETTLE) ||
                          (state_q == PUSH)   ||
                          (state_q == GAP);
  assign bus.load       = (state_q == ISSUE)  ||
                          (state_q == SETTLE) ||
                          (state_q == PUSH);
  assign bus.busy       = (state_q != IDLE);
  assign bus.digit      = digit_q;
  assign bus.done       = done_q;
  assign bus.fifo_count = count_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.overflow   = ovf_q;
  assign bus.bad_digit  = bad_q;
  assign bus.timeout    = tmo_q;
endmodule

// File: tb/tb_digit_sequencer.sv
// Random-stimulus bench for digit_sequencer against a queue and
// timeline reference model.
module tb_digit_sequencer;
  localparam int DEPTH = 8;
  localparam int HOLD  = 2;
  localparam int PUSH  = 5;
  localparam int GAP   = 3;
  localparam int TMO   = 20;
  localparam int L     = 300;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  digit_sequencer_if #(.DEPTH(DEPTH)) bus();

  digit_sequencer #(
    .DEPTH(DEPTH),
    .SETTLE_HOLD(HOLD),
    .PUSH_CYCLES(PUSH),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  int q[$];
  bit m_ovf, m_bad;
  int prev_dig;

  bit at[L];
  bit e_load[L], e_en[L], e_busy[L], e_done[L];
  int e_dig[L];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_fifo(input string tag);
    check({tag, "_count"}, 32'(bus.fifo_count), 32'(q.size()));
    check({tag, "_full"}, 32'(bus.full), 32'(q.size() == DEPTH));
    check({tag, "_empty"}, 32'(bus.empty), 32'(q.size() == 0));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(m_ovf));
    check({tag, "_bad"}, 32'(bus.bad_digit), 32'(m_bad));
  endtask

  task automatic wr(input int d, input bit clr);
    bus.wr_en     = 1'b1;
    bus.wr_digit  = 4'(d);
    bus.err_clear = clr;
    if (clr) begin
      m_ovf = 1'b0;
      m_bad = 1'b0;
    end
    if (d > 9)                  m_bad = 1'b1;
    else if (q.size() == DEPTH) m_ovf = 1'b1;
    else                        q.push_back(d);
    @(negedge clk);
    bus.wr_en     = 1'b0;
    bus.err_clear = 1'b0;
    check_fifo("wr");
  endtask

  task automatic clear_flags();
    bus.err_clear = 1'b1;
    @(negedge clk);
    bus.err_clear = 1'b0;
    m_ovf = 1'b0;
    m_bad = 1'b0;
    check("clr_ovf", 32'(bus.overflow), 32'(0));
    check("clr_bad", 32'(bus.bad_digit), 32'(0));
    check("clr_tmo", 32'(bus.timeout), 32'(0));
  endtask

  task automatic mark(input int i, input bit ld, input int dg);
    e_load[i] = ld;
    e_en[i]   = 1'b1;
    e_busy[i] = 1'b1;
    e_dig[i]  = dg;
  endtask

  task automatic run_round(input int r, input int phi);
    int n, d, t, s, streak, errt, popped, last, tail;
    int dq[$];
    bit ok;
    clear_flags();
    n = (r == 0) ? 9 : $urandom_range(1, 11);
    for (int j = 0; j < n; j++) begin
      if (r == 0 || j == 0 || $urandom_range(0, 4) != 0)
        d = $urandom_range(0, 9);
      else
        d = $urandom_range(10, 15);
      wr(d, r == 0 && j == n - 1);
    end
    clear_flags();

    // Expected timeline: ISSUE, SETTLE until HOLD highs in a row,
    // PUSH, GAP with done in its first cycle; or ERROR on timeout.
    for (int i = 0; i < L; i++) begin
      at[i]     = ($urandom_range(0, 99) < phi);
      e_load[i] = 1'b0;
      e_en[i]   = 1'b0;
      e_busy[i] = 1'b0;
      e_done[i] = 1'b0;
      e_dig[i]  = prev_dig;
    end
    dq = q;
    t = 1;
    errt = -1;
    popped = 0;
    last = prev_dig;
    while (dq.size() > 0 && errt < 0) begin
      d = dq.pop_front();
      popped++;
      last = d;
      mark(t, 1'b1, d);
      streak = 0;
      ok = 1'b0;
      s = t;
      for (int k = 0; k < TMO && !ok; k++) begin
        s = t + 1 + k;
        mark(s, 1'b1, d);
        streak = at[s] ? streak + 1 : 0;
        if (streak == HOLD) ok = 1'b1;
      end
      if (!ok) begin
        errt = s + 1;
      end else begin
        for (int p = 1; p <= PUSH; p++) mark(s + p, 1'b1, d);
        for (int g = 0; g < GAP; g++)
          mark(s + PUSH + 1 + g, 1'b0, d);
        e_done[s + PUSH + 1] = 1'b1;
        t = s + PUSH + GAP + 1;
      end
    end
    tail = (errt >= 0) ? errt : t;
    for (int i = tail; i < L; i++) begin
      e_dig[i]  = last;
      e_busy[i] = (errt >= 0);
    end

    bus.run = 1'b1;
    for (int i = 0; i < L; i++) begin
      check("load", 32'(bus.load), 32'(e_load[i]));
      check("en", 32'(bus.en), 32'(e_en[i]));
      check("busy", 32'(bus.busy), 32'(e_busy[i]));
      check("done", 32'(bus.done), 32'(e_done[i]));
      check("digit", 32'(bus.digit), 32'(e_dig[i]));
      bus.at_target = at[i];
      @(negedge clk);
    end
    bus.run = 1'b0;
    bus.at_target = 1'b0;
    check("timeout", 32'(bus.timeout), 32'(errt >= 0));
    if (errt >= 0) begin
      bus.err_clear = 1'b1;
      @(negedge clk);
      bus.err_clear = 1'b0;
      check("tmo_cleared", 32'(bus.timeout), 32'(0));
      check("err_to_idle", 32'(bus.busy), 32'(0));
    end
    check("remain", 32'(bus.fifo_count), 32'(q.size() - popped));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("flush_count", 32'(bus.fifo_count), 32'(0));
    check("flush_empty", 32'(bus.empty), 32'(1));
    q.delete();
    prev_dig = last;
  endtask

  initial begin
    reset         = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_digit  = 4'd0;
    bus.run       = 1'b0;
    bus.abort     = 1'b0;
    bus.err_clear = 1'b0;
    bus.at_target = 1'b0;
    m_ovf    = 1'b0;
    m_bad    = 1'b0;
    prev_dig = 0;
    repeat (2) @(negedge clk);
    check("rst_load", 32'(bus.load), 32'(0));
    check("rst_en", 32'(bus.en), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_digit", 32'(bus.digit), 32'(0));
    check_fifo("rst");
    check("rst_tmo", 32'(bus.timeout), 32'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 6; r++)
      run_round(r, (r == 2) ? 0 : ((r == 4) ? 60 : 90));

    // Abort in the middle of PUSH.
    wr(5, 1'b0);
    wr(3, 1'b0);
    bus.run = 1'b1;
    bus.at_target = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_pre_load", 32'(bus.load), 32'(1));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.run = 1'b0;
    check("abort_load", 32'(bus.load), 32'(0));
    check("abort_en", 32'(bus.en), 32'(0));
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_empty", 32'(bus.empty), 32'(1));
    check("abort_done", 32'(bus.done), 32'(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.done), 32'(0));
    end
    q.delete();
    prev_dig = 5;

    // Asynchronous reset while settling.
    wr(2, 1'b0);
    wr(8, 1'b0);
    bus.run = 1'b1;
    bus.at_target = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_load", 32'(bus.load), 32'(1));
    #2 reset = 1'b1;
    #1;
    check("arst_load", 32'(bus.load), 32'(0));
    check("arst_en", 32'(bus.en), 32'(0));
    check("arst_busy", 32'(bus.busy), 32'(0));
    check("arst_empty", 32'(bus.empty), 32'(1));
    check("arst_digit", 32'(bus.digit), 32'(0));
    @(negedge clk);
    bus.run = 1'b0;
    reset = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_bad = 1'b0;
    prev_dig = 0;
    @(negedge clk);
    check_fifo("post_rst");
    run_round(1, 90);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
